// File: rtl/right_shift_seq.sv
// Multi-cycle 16-bit right rotator / logical right shifter: one bit position per clock,
// with a Start/Busy/Done handshake and a registered result that holds until the next operation.
module right_shift_seq #(
  parameter int WIDTH   = 16,
  parameter int RANGE_W = 4
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               Start,
  input  logic [WIDTH-1:0]   Number,
  input  logic [RANGE_W-1:0] Range,
  input  logic               Mode,
  output logic               Busy,
  output logic               Done,
  output logic [WIDTH-1:0]   Shiftedo,
  output logic [1:0]         dbg_state_o
);

  // Handshake: Start is sampled only in IDLE; once accepted, Busy stays high through
  // the SHIFT and DONE states, and Done pulses for exactly the one cycle in which
  // Shiftedo first carries the new result. Start seen while Busy is dropped, not queued.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [RANGE_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic               mode_q, mode_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               fill_bit;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      data_q   <= '0;
      mode_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      data_q   <= data_d;
      mode_q   <= mode_d;
      result_q <= result_d;
    end
  end

  // Rotate wraps the outgoing LSB into the MSB; logical shift fills with zero.
  assign fill_bit = mode_q ? 1'b0 : data_q[0];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    data_d   = data_q;
    mode_d   = mode_q;
    result_d = result_q;
    Busy     = 1'b0;
    Done     = 1'b0;
    case (state_q)
      IDLE: begin
        if (Start) begin
          data_d  = Number;
          cnt_d   = Range;
          mode_d  = Mode;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        Busy = 1'b1;
        if (cnt_q != '0) begin
          data_d = {fill_bit, data_q[WIDTH-1:1]};
          cnt_d  = cnt_q - RANGE_W'(1);
        end else begin
          result_d = data_q;
          state_d  = DONE;
        end
      end
      DONE: begin
        Busy    = 1'b1;
        Done    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign Shiftedo    = result_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_right_shift_seq.sv
// Directed bench for right_shift_seq: a cycle-level reference model checked every cycle,
// plus hand-computed results and latencies for each directed operation.
module tb_right_shift_seq;

  logic        Clock;
  logic        Reset;
  logic        Start;
  logic [15:0] Number;
  logic [3:0]  Range;
  logic        Mode;
  logic        Busy;
  logic        Done;
  logic [15:0] Shiftedo;
  logic [1:0]  dbg_state;

  int total = 0;
  int bad   = 0;

  right_shift_seq #(.WIDTH(16), .RANGE_W(4)) dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .Start      (Start),
    .Number     (Number),
    .Range      (Range),
    .Mode       (Mode),
    .Busy       (Busy),
    .Done       (Done),
    .Shiftedo   (Shiftedo),
    .dbg_state_o(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // ---------------- reference model ----------------
  function automatic logic [15:0] ref_result(input logic [15:0] x, input int r, input logic m);
    logic [31:0] wide;
    if (m) return x >> r;
    if (r == 0) return x;
    wide = ({16'h0, x} >> r) | ({16'h0, x} << (16 - r));
    return wide[15:0];
  endfunction

  int          cyc       = 0;
  bit          m_active  = 0;
  int          m_done_at = -1;
  logic [15:0] m_pending = '0;
  logic [15:0] m_res     = '0;

  // An operation accepted at edge a shows Done after edge a+Range+1 and frees the
  // block at edge a+Range+2; a Start seen on that freeing edge is ignored.
  always @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      m_active  = 0;
      m_done_at = -1;
      m_res     = '0;
    end else begin
      cyc++;
      if (m_active && (cyc - 1 == m_done_at)) begin
        m_active = 0;
      end else if (!m_active && Start) begin
        m_active  = 1;
        m_done_at = cyc + int'(Range) + 1;
        m_pending = ref_result(Number, int'(Range), Mode);
      end
      if (m_active && cyc == m_done_at) m_res = m_pending;
    end
  end

  // ---------------- scoreboard compare ----------------
  always @(negedge Clock) begin
    logic exp_busy, exp_done;
    exp_busy = m_active;
    exp_done = m_active && (cyc == m_done_at);
    total++;
    if (Busy !== exp_busy) begin
      bad++;
      $display("FAIL model_busy cyc=%0d got=%b exp=%b", cyc, Busy, exp_busy);
    end
    total++;
    if (Done !== exp_done) begin
      bad++;
      $display("FAIL model_done cyc=%0d got=%b exp=%b", cyc, Done, exp_done);
    end
    total++;
    if (Shiftedo !== m_res) begin
      bad++;
      $display("FAIL model_result cyc=%0d got=%h exp=%h", cyc, Shiftedo, m_res);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic start_op(input logic [15:0] num, input logic [3:0] rng, input logic m);
    @(negedge Clock);
    #1;
    Start  = 1'b1;
    Number = num;
    Range  = rng;
    Mode   = m;
    @(posedge Clock);
    #1;
    Start  = 1'b0;
    Number = 16'($urandom_range(0, 65535));
    Range  = 4'($urandom_range(0, 15));
    Mode   = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_done(input int exp_lat, input logic [15:0] exp_val, input string name);
    int lat;
    bit seen;
    lat  = 0;
    seen = 0;
    while (!seen && lat < 40) begin
      @(negedge Clock);
      lat++;
      if (Done === 1'b1) seen = 1;
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL %s_timeout no Done within %0d cycles", name, lat);
    end else begin
      if (lat != exp_lat) begin
        bad++;
        $display("FAIL %s_latency got=%0d exp=%0d", name, lat, exp_lat);
      end
      total++;
      if (Shiftedo !== exp_val) begin
        bad++;
        $display("FAIL %s_result got=%h exp=%h", name, Shiftedo, exp_val);
      end
    end
  endtask

  task automatic check_idle_next(input string name);
    @(negedge Clock);
    total++;
    if (Busy !== 1'b0) begin
      bad++;
      $display("FAIL %s_idle busy got=%b exp=0", name, Busy);
    end
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    Reset  = 1'b1;
    Start  = 1'b0;
    Number = '0;
    Range  = '0;
    Mode   = 1'b0;
    repeat (2) @(negedge Clock);
    #1;
    total++;
    if ({Busy, Done, Shiftedo} !== 18'h0) begin
      bad++;
      $display("FAIL reset_state got busy=%b done=%b res=%h exp 0/0/0000", Busy, Done, Shiftedo);
    end
    Reset = 1'b0;

    start_op(16'h8001, 4'd1, 1'b0);
    wait_done(3, 16'hC000, "rot_8001_r1");
    check_idle_next("rot_8001_r1");

    start_op(16'h1234, 4'd4, 1'b0);
    wait_done(6, 16'h4123, "rot_1234_r4");
    start_op(16'h1234, 4'd4, 1'b1);
    wait_done(6, 16'h0123, "lsr_1234_r4");

    start_op(16'hABCD, 4'd0, 1'b0);
    wait_done(2, 16'hABCD, "r0_abcd");

    start_op(16'h8000, 4'd15, 1'b0);
    wait_done(17, 16'h0001, "rot_8000_r15");
    start_op(16'h8000, 4'd15, 1'b1);
    wait_done(17, 16'h0001, "lsr_8000_r15");
    start_op(16'h0001, 4'd15, 1'b0);
    wait_done(17, 16'h0002, "rot_0001_r15");

    // Second request held through the whole busy window, including the DONE cycle.
    start_op(16'h00F0, 4'd4, 1'b0);
    Start  = 1'b1;
    Number = 16'hFFFF;
    Range  = 4'd1;
    Mode   = 1'b0;
    wait_done(6, 16'h000F, "busy_ignore");
    check_idle_next("busy_ignore");
    #1;
    Start = 1'b0;
    repeat (4) @(negedge Clock);
    total++;
    if (Shiftedo !== 16'h000F) begin
      bad++;
      $display("FAIL busy_ignore_hold got=%h exp=000f", Shiftedo);
    end

    // Reset in the middle of an operation.
    start_op(16'h1234, 4'd8, 1'b0);
    @(negedge Clock);
    #1;
    Reset = 1'b1;
    #1;
    total++;
    if ({Busy, Done, Shiftedo} !== 18'h0) begin
      bad++;
      $display("FAIL midop_reset got busy=%b done=%b res=%h exp 0/0/0000", Busy, Done, Shiftedo);
    end
    repeat (3) @(negedge Clock);
    #1;
    Reset  = 1'b0;
    Start  = 1'b1;
    Number = 16'h00F1;
    Range  = 4'd2;
    Mode   = 1'b0;
    @(posedge Clock);
    #1;
    Start = 1'b0;
    wait_done(4, 16'h403C, "after_reset");
    check_idle_next("after_reset");

    repeat (3) @(negedge Clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
